shift_seq8: RTL

SHIFT_SEQ8 -- requirements
Module: shift_seq8

---
 rtl/shift_seq8_pkg.sv | 47 ++++
 rtl/shift_seq8_shifter8.sv | 48 ++++
 rtl/shift_seq8.sv | 115 +++++++++++
 3 files changed

// File: rtl/shift_seq8_pkg.sv
// ============================================================================
// Module   : shift_seq8_pkg
// Purpose  : Shared encodings and helpers for the shift_seq8 sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_seq8_pkg;

    localparam int unsigned MAX_STEP = 3;

    // Sequencer FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Request operation select codes
    typedef logic [1:0] opsel_t;
    localparam opsel_t OPSEL_LSL  = 2'b00;
    localparam opsel_t OPSEL_LSR  = 2'b01;
    localparam opsel_t OPSEL_ASR  = 2'b10;
    localparam opsel_t OPSEL_RSVD = 2'b11;

    // Shifter datapath op codes
    typedef logic [2:0] shop_t;
    localparam shop_t SH_NOP  = 3'b000;
    localparam shop_t SH_LOAD = 3'b001;
    localparam shop_t SH_LSL  = 3'b010;
    localparam shop_t SH_LSR  = 3'b011;
    localparam shop_t SH_ASR  = 3'b100;

    // Largest step the 2-bit shifter can take toward the remaining distance
    function automatic logic [1:0] step_size(input logic [2:0] remaining);
        logic [1:0] step;
        if (remaining > 3'(MAX_STEP)) begin
            step = 2'(MAX_STEP);
        end else begin
            step = remaining[1:0];
        end
        return step;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_seq8_shifter8.sv
// ============================================================================
// Module   : shifter8
// Purpose  : 8-bit register with load and 0..3 bit LSL/LSR/ASR per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shifter8
    import shift_seq8_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] i_op,
    input  logic [1:0] i_shamt,
    input  logic [7:0] i_d_in,
    output logic [7:0] o_d_out
);

    logic [7:0]        data_q;
    logic [7:0]        data_d;
    logic signed [7:0] w_signed;

    assign w_signed = data_q;

    always_comb begin
        data_d = data_q;
        case (i_op)
            SH_LOAD: data_d = i_d_in;
            SH_LSL:  data_d = data_q << i_shamt;
            SH_LSR:  data_d = data_q >> i_shamt;
            SH_ASR:  data_d = w_signed >>> i_shamt;
            default: data_d = data_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= 8'h00;
        end else begin
            data_q <= data_d;
        end
    end

    assign o_d_out = data_q;

endmodule

`default_nettype wire

// File: rtl/shift_seq8.sv
// ============================================================================
// Module   : shift_seq8
// Purpose  : Sequences a 0..7 bit shift request into <=3-bit shifter steps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_seq8
    import shift_seq8_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op_sel,
    input  logic [2:0] amount,
    input  logic [7:0] d_in,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] d_out
);

    state_t     state_q, state_d;
    opsel_t     op_q,    op_d;
    logic [2:0] rem_q,   rem_d;
    logic [7:0] data_q,  data_d;

    logic [1:0] w_step;
    shop_t      w_sh_op;
    logic [1:0] w_sh_amt;

    assign w_step = step_size(rem_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OPSEL_LSL;
            rem_q   <= 3'd0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op_sel;
                    data_d  = d_in;
                    // Reserved op only loads, so it carries no shift distance
                    rem_d   = (op_sel == OPSEL_RSVD) ? 3'd0 : amount;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = (rem_q != 3'd0) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                rem_d = rem_q - {1'b0, w_step};
                if (rem_d == 3'd0) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_sh_op  = SH_NOP;
        w_sh_amt = 2'd0;
        case (state_q)
            ST_LOAD: begin
                w_sh_op = SH_LOAD;
            end
            ST_SHIFT: begin
                w_sh_amt = w_step;
                case (op_q)
                    OPSEL_LSL: w_sh_op = SH_LSL;
                    OPSEL_LSR: w_sh_op = SH_LSR;
                    OPSEL_ASR: w_sh_op = SH_ASR;
                    default:   w_sh_op = SH_NOP;
                endcase
            end
            default: begin
                w_sh_op = SH_NOP;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign err  = (state_q == ST_DONE) && (op_q == OPSEL_RSVD);

    shifter8 u_shifter8 (
        .clk     (clk),
        .reset_n (~reset),
        .i_op    (w_sh_op),
        .i_shamt (w_sh_amt),
        .i_d_in  (data_q),
        .o_d_out (d_out)
    );

endmodule

`default_nettype wire
